// File: rtl/data_memory_ctrl.sv
// Single-port data memory controller for the MEM stage.
// The array is an inferred synchronous-read RAM with byte-enable writes. Reads
// take a configurable number of cycles, and the pipeline is stalled while an
// access is in flight. Out-of-range addresses are flagged, and such reads return 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting; a request is accepted and (for writes) committed here
// BUSY  | extra read-latency cycles, counter runs down to 1
// DONE  | access retires; read data / rd_valid / addr_err presented
module data_memory_ctrl #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8192,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    write,
  input  logic                    read,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    addr_err,
  output logic                    stall
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0]          CNT_INIT  = 2'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  // Parameter legality is enforced at elaboration time.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("data_memory_ctrl: READ_LATENCY must be in 1..4");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("data_memory_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || IDX_W > ADDR_WIDTH) begin : g_bad_depth
    $error("data_memory_ctrl: DEPTH must fit in the address space");
  end

  logic [1:0]            state;
  logic [1:0]            cnt;
  logic                  req_rd;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic             is_idle;
  logic             req_any;
  logic             op_rd_live;
  logic             in_range;
  logic             req_in_range;
  logic             wr_fire;
  logic             rd_fire;
  logic             busy_last;
  logic             done_nxt;
  logic             done_rd;
  logic             done_oor;
  logic [IDX_W-1:0] idx;

  assign is_idle      = (state == ST_IDLE);
  assign req_any      = read | write;
  // A simultaneous read and write is treated as a write only.
  assign op_rd_live   = read & ~write;
  assign in_range     = ({1'b0, address}  < DEPTH_LIM);
  assign req_in_range = ({1'b0, req_addr} < DEPTH_LIM);
  assign idx          = address[IDX_W-1:0];
  // Gating with rst_n means that a write held during reset can never commit.
  assign wr_fire      = rst_n & is_idle & write & in_range;
  assign rd_fire      = rst_n & is_idle & op_rd_live;
  assign busy_last    = (state == ST_BUSY) && (cnt == 2'd1);

  // With unit latency, DONE is entered straight from IDLE, so the live inputs are used.
  assign done_nxt = (READ_LATENCY == 1) ? (is_idle & req_any) : busy_last;
  assign done_rd  = (READ_LATENCY == 1) ? op_rd_live : req_rd;
  assign done_oor = (READ_LATENCY == 1) ? ~in_range : ~req_in_range;

  assign stall = is_idle ? req_any : (state == ST_BUSY);

  // Access sequencing: accept in IDLE, count out the latency in BUSY, retire in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 2'd0;
      req_rd   <= 1'b0;
      req_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            req_rd   <= op_rd_live;
            req_addr <= address;
            if (READ_LATENCY == 1) begin
              state <= ST_DONE;
            end else begin
              state <= ST_BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion pulses are valid for exactly the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= done_nxt & done_rd;
      addr_err <= done_nxt & done_oor;
    end
  end

  // Byte-masked write commits on the edge that ends the IDLE request cycle.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    // data_out doubles as the RAM output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       data_out <= '0;
      else if (rd_fire) data_out <= in_range ? mem[idx] : '0;
    end
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] pipe [0:READ_LATENCY-2];

    // RAM read followed by a free-running output pipeline. No write can
    // occur while a read is in flight, so the pipeline contents stay coherent.
    always_ff @(posedge clk) begin
      if (rd_fire) pipe[0] <= mem[idx];
      for (int k = 1; k < READ_LATENCY - 1; k++) pipe[k] <= pipe[k-1];
    end

    // The last pipeline stage is loaded into data_out on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                data_out <= '0;
      else if (busy_last & req_rd) data_out <= req_in_range ? pipe[READ_LATENCY-2] : '0;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance with unit latency, one with
// latency 3. Each instance has its own reset so that the latency-3 instance
// can be reset mid-access.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_write, a_read, a_rd_valid, a_addr_err, a_stall;
  logic [15:0] a_addr;
  logic [31:0] a_din, a_dout;
  logic [3:0]  a_be;

  logic        b_rst_n, b_write, b_read, b_rd_valid, b_addr_err, b_stall;
  logic [15:0] b_addr;
  logic [31:0] b_din, b_dout;
  logic [3:0]  b_be;

  int n_checks = 0;
  int n_errors = 0;

  data_memory_ctrl #(.READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(a_rst_n), .address(a_addr), .data_in(a_din), .byte_en(a_be),
    .write(a_write), .read(a_read), .data_out(a_dout), .rd_valid(a_rd_valid),
    .addr_err(a_addr_err), .stall(a_stall)
  );

  data_memory_ctrl #(.READ_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(b_rst_n), .address(b_addr), .data_in(b_din), .byte_en(b_be),
    .write(b_write), .read(b_read), .data_out(b_dout), .rd_valid(b_rd_valid),
    .addr_err(b_addr_err), .stall(b_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit sel_b, input logic w, input logic r, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    if (sel_b) begin
      b_write = w; b_read = r; b_addr = a; b_din = d; b_be = be;
    end else begin
      a_write = w; a_read = r; a_addr = a; a_din = d; a_be = be;
    end
  endtask

  // One complete access starting from IDLE. Requests drop and inputs are
  // scrambled after acceptance; the result is checked in the DONE cycle.
  task automatic access(input bit sel_b, input int lat, input logic w, input logic r,
                        input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic exp_v, input logic exp_e, input logic [31:0] exp_do,
                        input string tag);
    @(posedge clk); #1;
    set_in(sel_b, w, r, a, d, be);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check({tag, " stall_hi"}, sel_b ? b_stall : a_stall, 32'd1);
      check({tag, " rdv_early"}, sel_b ? b_rd_valid : a_rd_valid, 32'd0);
      @(posedge clk); #1;
      set_in(sel_b, 1'b0, 1'b0, ~a, ~d, ~be);
    end
    @(negedge clk);
    check({tag, " stall_done"}, sel_b ? b_stall : a_stall, 32'd0);
    check({tag, " rd_valid"}, sel_b ? b_rd_valid : a_rd_valid, 32'(exp_v));
    check({tag, " addr_err"}, sel_b ? b_addr_err : a_addr_err, 32'(exp_e));
    check({tag, " data_out"}, sel_b ? b_dout : a_dout, exp_do);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 4'd0);
    set_in(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 4'd0);
    #12;
    check("rst data_out", a_dout, 32'd0);
    check("rst rd_valid", a_rd_valid, 32'd0);
    check("rst addr_err", a_addr_err, 32'd0);
    check("rst stall_idle", a_stall, 32'd0);
    a_read = 1'b1; #1;
    check("rst stall_req", a_stall, 32'd1);
    a_read = 1'b0;
    #9;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Unit latency instance
    access(0, 1, 1, 0, 16'd5,      32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        "wr5");
    access(0, 1, 0, 1, 16'd5,      32'h0,        4'h0, 1, 0, 32'hDEADBEEF, "rd5");
    access(0, 1, 1, 0, 16'd9,      32'h11223344, 4'hF, 0, 0, 32'hDEADBEEF, "wr9a");
    access(0, 1, 1, 0, 16'd9,      32'hAABBCCDD, 4'h5, 0, 0, 32'hDEADBEEF, "wr9b");
    access(0, 1, 0, 1, 16'd9,      32'h0,        4'h0, 1, 0, 32'h11BB33DD, "rd9");
    access(0, 1, 1, 0, 16'd0,      32'h01020304, 4'hF, 0, 0, 32'h11BB33DD, "wr0");
    access(0, 1, 1, 0, 16'h2000,   32'h12345678, 4'hF, 0, 1, 32'h11BB33DD, "wr_oor");
    access(0, 1, 0, 1, 16'h2000,   32'h0,        4'h0, 1, 1, 32'h0,        "rd_oor");
    access(0, 1, 0, 1, 16'd0,      32'h0,        4'h0, 1, 0, 32'h01020304, "rd0");
    access(0, 1, 1, 1, 16'd3,      32'hCAFEF00D, 4'hF, 0, 0, 32'h01020304, "rw3");
    access(0, 1, 0, 1, 16'd3,      32'h0,        4'h0, 1, 0, 32'hCAFEF00D, "rd3");
    access(0, 1, 1, 0, 16'd3,      32'hFFFFFFFF, 4'h0, 0, 0, 32'hCAFEF00D, "wr3_be0");
    access(0, 1, 0, 1, 16'd3,      32'h0,        4'h0, 1, 0, 32'hCAFEF00D, "rd3_be0");
    access(0, 1, 1, 0, 16'h1FFF,   32'h80000001, 4'hF, 0, 0, 32'hCAFEF00D, "wr_top");
    access(0, 1, 0, 1, 16'h1FFF,   32'h0,        4'h0, 1, 0, 32'h80000001, "rd_top");
    access(0, 1, 0, 1, 16'hFFFF,   32'h0,        4'h0, 1, 1, 32'h0,        "rd_ffff");

    // Latency-3 instance
    access(1, 3, 1, 0, 16'd5,      32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        "l3 wr5");
    access(1, 3, 0, 1, 16'd5,      32'h0,        4'h0, 1, 0, 32'hDEADBEEF, "l3 rd5");

    // Held read: stall 1,1,1,0 and one rd_valid every fourth cycle
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b1, 16'd5, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("held stall c%0d", i), b_stall, (i % 4 != 3) ? 32'd1 : 32'd0);
      check($sformatf("held rdv c%0d", i), b_rd_valid, (i % 4 == 3) ? 32'd1 : 32'd0);
      check($sformatf("held dout c%0d", i), b_dout, 32'hDEADBEEF);
      @(posedge clk);
    end
    #1;
    set_in(1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);

    access(1, 3, 1, 0, 16'd6,      32'h600D600D, 4'hF, 0, 0, 32'hDEADBEEF, "l3 wr6");

    // Reset while a read sits in BUSY
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b1, 16'd6, 32'h0, 4'h0);
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
    @(negedge clk);
    check("mid_rst busy_stall", b_stall, 32'd1);
    #1 b_rst_n = 1'b0;
    #1;
    check("mid_rst data_out", b_dout, 32'd0);
    check("mid_rst rd_valid", b_rd_valid, 32'd0);
    check("mid_rst addr_err", b_addr_err, 32'd0);
    check("mid_rst stall", b_stall, 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1;

    access(1, 3, 0, 1, 16'd6,      32'h0,        4'h0, 1, 0, 32'h600D600D, "l3 rd6");
    access(1, 3, 0, 1, 16'd5,      32'h0,        4'h0, 1, 0, 32'hDEADBEEF, "l3 rd5b");
    access(1, 3, 0, 1, 16'h2000,   32'h0,        4'h0, 1, 1, 32'h0,        "l3 rd_oor");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
